// File: rtl/kapi_kilidi_fsm.sv
// Sequential code lock: collects strobed digits, compares them with a reprogrammable
// code, drives a timed door-release pulse and a timed alarm, and registers the doorbell.
module kapi_kilidi_fsm #(
  parameter int DIGIT_W     = 4,
  parameter int CODE_LEN    = 4,
  parameter int MAX_DENEME  = 3,
  parameter int ACIK_SURE   = 16,
  parameter int ALARM_SURE  = 32,
  parameter int ZAMAN_ASIMI = 64,
  parameter logic [CODE_LEN*DIGIT_W-1:0] SIFRE_VARSAYILAN = 16'h1234
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DIGIT_W-1:0]                sayi_girisi,
  input  logic                              sayi_gecerli,
  input  logic                              sifre_butonu,
  input  logic                              sifre_degistir,
  input  logic                              zil_butonu,
  output logic [DIGIT_W-1:0]                cikis,
  output logic                              zil,
  output logic                              kapi_ac,
  output logic                              alarm,
  output logic [$clog2(MAX_DENEME+1)-1:0]   hata_sayisi,
  output logic [2:0]                        durum
);

  localparam int CODE_W = CODE_LEN * DIGIT_W;
  localparam int CNT_W  = $clog2(CODE_LEN + 2);
  localparam int HATA_W = $clog2(MAX_DENEME + 1);
  localparam int T_AB   = (ACIK_SURE > ALARM_SURE) ? ACIK_SURE : ALARM_SURE;
  localparam int T_MAX  = (T_AB > ZAMAN_ASIMI) ? T_AB : ZAMAN_ASIMI;
  localparam int TMR_W  = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    BEKLE = 3'd0,
    GIRIS = 3'd1,
    ACIK  = 3'd2,
    PROG  = 3'd3,
    ALARM = 3'd4
  } durum_e;

  durum_e              durum_q, durum_d;
  logic [CODE_W-1:0]   kod_q, kod_d;
  logic [CODE_W-1:0]   tampon_q, tampon_d;
  logic [CNT_W-1:0]    sayac_q, sayac_d;
  logic [TMR_W-1:0]    zaman_q, zaman_d;
  logic [HATA_W-1:0]   hata_q, hata_d;
  logic                zil_onceki_q, zil_q, zil_d;
  logic [DIGIT_W-1:0]  cikis_q, cikis_d;

  logic [CODE_W-1:0]   tampon_kaydir;
  logic [CNT_W-1:0]    sayac_art;
  logic [HATA_W-1:0]   hata_art;
  logic                eslesme;

  // NOTE: the stored code is a plain register, so it takes the reset value like any other state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      durum_q      <= BEKLE;
      kod_q        <= SIFRE_VARSAYILAN;
      tampon_q     <= '0;
      sayac_q      <= '0;
      zaman_q      <= '0;
      hata_q       <= '0;
      zil_onceki_q <= 1'b0;
      zil_q        <= 1'b0;
      cikis_q      <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      durum_q      <= durum_d;
      kod_q        <= kod_d;
      tampon_q     <= tampon_d;
      sayac_q      <= sayac_d;
      zaman_q      <= zaman_d;
      hata_q       <= hata_d;
      zil_onceki_q <= zil_butonu;
      zil_q        <= zil_d;
      cikis_q      <= cikis_d;
    end
  end

  assign tampon_kaydir = (tampon_q << DIGIT_W) | CODE_W'(sayi_girisi);
  assign sayac_art     = (sayac_q == CNT_W'(CODE_LEN + 1)) ? sayac_q : sayac_q + CNT_W'(1);
  assign hata_art      = hata_q + HATA_W'(1);
  assign eslesme       = (sayac_q == CNT_W'(CODE_LEN)) && (tampon_q == kod_q);

  always_comb begin
    // NOTE: every target gets a default first so no path leaves one unassigned (no latches).
    durum_d  = durum_q;
    kod_d    = kod_q;
    tampon_d = tampon_q;
    sayac_d  = sayac_q;
    zaman_d  = zaman_q;
    hata_d   = hata_q;
    zil_d    = zil_butonu & ~zil_onceki_q;
    cikis_d  = sayi_girisi & {DIGIT_W{zil_butonu}};

    unique case (durum_q)
      BEKLE: begin
        if (sayi_gecerli) begin
          durum_d  = GIRIS;
          tampon_d = CODE_W'(sayi_girisi);
          sayac_d  = CNT_W'(1);
        end
      end
      GIRIS, PROG: begin
        // A submit in the same cycle as a digit wins; the digit is dropped.
        if (sifre_butonu) begin
          durum_d = BEKLE;
          if (durum_q == GIRIS) begin
            if (eslesme) begin
              durum_d = ACIK;
              hata_d  = '0;
            end else begin
              hata_d = hata_art;
              if (hata_art == HATA_W'(MAX_DENEME)) durum_d = ALARM;
            end
          end else if (sayac_q == CNT_W'(CODE_LEN)) begin
            kod_d = tampon_q;
          end
        end else if (sayi_gecerli) begin
          tampon_d = tampon_kaydir;
          sayac_d  = sayac_art;
          zaman_d  = '0;
        end else if (zaman_q == TMR_W'(ZAMAN_ASIMI - 1)) begin
          durum_d = BEKLE;
        end else begin
          zaman_d = zaman_q + TMR_W'(1);
        end
      end
      ACIK: begin
        if (sifre_degistir)                              durum_d = PROG;
        else if (zaman_q == TMR_W'(ACIK_SURE - 1))       durum_d = BEKLE;
        else                                             zaman_d = zaman_q + TMR_W'(1);
      end
      ALARM: begin
        if (zaman_q == TMR_W'(ALARM_SURE - 1)) begin
          durum_d = BEKLE;
          hata_d  = '0;
        end else begin
          zaman_d = zaman_q + TMR_W'(1);
        end
      end
      default: durum_d = BEKLE;
    endcase

    // Timer restarts on every state entry; the entry buffer clears on every exit
    // except BEKLE -> GIRIS, which has just loaded the first digit.
    if (durum_d != durum_q) begin
      zaman_d = '0;
      if (durum_q != BEKLE) begin
        tampon_d = '0;
        sayac_d  = '0;
      end
    end
  end

  always_comb begin
    durum       = durum_q;
    kapi_ac     = (durum_q == ACIK);
    alarm       = (durum_q == ALARM);
    hata_sayisi = hata_q;
    zil         = zil_q & (durum_q != ALARM);
    cikis       = (durum_q == ALARM) ? '0 : cikis_q;
  end

endmodule

// File: doc/kapi_kilidi_fsm.md
Name: kapi_kilidi_fsm

Overview:
Parametrised sequential successor of the combinational doorbell/code gate. It collects a multi-digit code one strobed digit at a time and compares it against a stored, reprogrammable code. It drives a timed door-open pulse, counts failed attempts and raises a timed alarm after too many failures. It also keeps the doorbell digit pass-through as a registered output and sits between the keypad/button debouncers and the door actuator/siren drivers.

Parameters:
DIGIT_W, 4, bits per entered digit
CODE_LEN, 4, number of digits in a code (>=1)
MAX_DENEME, 3, consecutive wrong attempts that trigger ALARM (>=1)
ACIK_SURE, 16, cycles kapi_ac stays high after a correct code
ALARM_SURE, 32, cycles alarm stays high
ZAMAN_ASIMI, 64, idle cycles in GIRIS/PROG before abort
SIFRE_VARSAYILAN, 16'h1234, reset code, CODE_LEN*DIGIT_W bits, first entered digit in the MS slot

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-low
sayi_girisi  in  DIGIT_W  keypad digit value
sayi_gecerli  in  1  1-cycle strobe, sayi_girisi valid
sifre_butonu  in  1  1-cycle strobe, submit entered digits
sifre_degistir  in  1  1-cycle strobe, request code programming (honoured only in ACIK)
zil_butonu  in  1  doorbell button level (debounced upstream)
cikis  out  DIGIT_W  registered doorbell digit
zil  out  1  1-cycle pulse on zil_butonu rising edge
kapi_ac  out  1  door release
alarm  out  1  siren
hata_sayisi  out  $clog2(MAX_DENEME+1)  consecutive wrong attempts
durum  out  3  state: 0 BEKLE, 1 GIRIS, 2 ACIK, 3 PROG, 4 ALARM

Behaviour:
- Reset (rst_n=0 at an edge): state BEKLE, stored code = SIFRE_VARSAYILAN, entry buffer/digit count/timers/hata_sayisi = 0, all outputs 0. Reset mid-operation aborts everything, including ACIK, ALARM and PROG; a code being programmed is discarded.
- Entry buffer: on each accepted digit, buffer <= {buffer[(CODE_LEN-1)*DIGIT_W-1:0], sayi_girisi}. The count saturates at CODE_LEN+1; any count other than CODE_LEN means a wrong length.
- BEKLE: a sayi_gecerli strobe loads the first digit (count=1) and moves to GIRIS. sifre_butonu and sifre_degistir are ignored.
- GIRIS:
  - Each sayi_gecerli strobe shifts in a digit and clears the idle timer.
  - On sifre_butonu: match iff count==CODE_LEN and buffer==code.
  - Match: go to ACIK and clear hata_sayisi.
  - Mismatch: increment hata_sayisi. If the new value equals MAX_DENEME, go to ALARM; otherwise go to BEKLE.
  - The buffer and count clear on every exit.
  - If sifre_butonu and sayi_gecerli arrive in the same cycle, the submit wins and the digit is dropped.
  - The idle timer reaching ZAMAN_ASIMI returns to BEKLE with no attempt counted.
- ACIK:
  - kapi_ac=1 from the first cycle in the state (registered, 1 cycle after the submit edge) for exactly ACIK_SURE cycles, then BEKLE.
  - sifre_degistir enters PROG and drops kapi_ac the next cycle.
  - Digits are ignored.
- PROG:
  - Digits are collected as in GIRIS, with its own idle timer.
  - sifre_butonu with count==CODE_LEN stores the buffer as the new code.
  - Any other count leaves the code unchanged.
  - Either way, go to BEKLE.
  - Timeout goes to BEKLE with the code unchanged.
  - hata_sayisi is unaffected.
- ALARM: alarm=1 for exactly ALARM_SURE cycles, then BEKLE with hata_sayisi=0. All digit, submit and program strobes are ignored; a correct code does not cancel the alarm.
- Doorbell:
  - zil_butonu is registered once for edge detection. A rising edge gives zil=1 for one cycle.
  - cikis <= sayi_girisi & {DIGIT_W{zil_butonu}}, 1-cycle latency.
  - In ALARM, zil and cikis are forced to 0.
  - The doorbell is independent of the lock FSM in all other states.
- Timers use $clog2(max+1) widths; there is no wrap, and each timer clears on state entry.
- hata_sayisi never exceeds MAX_DENEME.

Test Plan:
- Reset, digits 1,2,3,4 then sifre_butonu -> durum 2, kapi_ac high exactly 16 cycles, hata_sayisi 0, then durum 0.
- Digits 1,2,3,5 submit three times -> hata_sayisi 1,2; on the third, alarm=1 for 32 cycles. Correct code during ALARM is ignored; afterwards durum 0, hata_sayisi 0.
- Digits 1,2 then 64 idle cycles -> back to BEKLE, hata_sayisi unchanged. Digits 1,2,3,4,4 then submit -> counted wrong (length).
- Correct code, sifre_degistir in ACIK, digits 9,8,7,6 then submit -> kapi_ac drops. Old code 1234 is now rejected; 9876 opens. A PROG submit with 3 digits keeps 9876.
- Digit 4 and sifre_butonu in the same cycle after 1,2,3 -> wrong attempt, hata_sayisi 1.
- zil_butonu held 5 cycles with sayi_girisi=4'hA -> zil single pulse, cikis=4'hA one cycle after the press, 0 one cycle after release. rst_n low during ACIK -> kapi_ac 0 next edge, code 1234.
